// File: rtl/mc_mem_pkg.sv
// rtl/mc_mem_pkg.sv - shared types and byte-lane helpers for the memory responder
package mc_mem_pkg;

  localparam int WORD_W = 32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
    return {lane, 3'b000};
  endfunction

  function automatic logic [WORD_W-1:0] lane_mask(input logic [1:0] lane);
    return 32'h0000_00FF << lane_lsb(lane);
  endfunction

endpackage

// File: rtl/mc_byte_lane.sv
// rtl/mc_byte_lane.sv - little-endian lane extract with sign extension and lane merge
module mc_byte_lane
  import mc_mem_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        lane_i,
  input  logic [7:0]        wbyte_i,
  output logic [WORD_W-1:0] sext_o,
  output logic [WORD_W-1:0] merged_o
);

  logic [WORD_W-1:0] shifted;
  logic [7:0]        lane_byte;

  assign shifted   = word_i >> lane_lsb(lane_i);
  assign lane_byte = shifted[7:0];
  assign sext_o    = {{(WORD_W-8){lane_byte[7]}}, lane_byte};

  assign merged_o = (word_i & ~lane_mask(lane_i))
                  | ({{(WORD_W-8){1'b0}}, wbyte_i} << lane_lsb(lane_i));

endmodule

// File: rtl/mc_mem_responder.sv
// rtl/mc_mem_responder.sv - wait-stated word/byte memory responder, one request in flight
module mc_mem_responder
  import mc_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                byte_q, byte_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          lane_q, lane_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [WORD_W-1:0]   mem_q [2**ADDR_W];

  logic                access;
  logic                misalign;
  logic [WORD_W-1:0]   word_rd;
  logic [WORD_W-1:0]   lane_sext;
  logic [WORD_W-1:0]   lane_merged;
  logic                unused_addr_bits;

  // Upper address bits alias onto the array by design.
  assign unused_addr_bits = ^req_addr[WORD_W-1:ADDR_W+2];

  assign access   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign misalign = !byte_q && (lane_q != 2'b00);
  assign word_rd  = mem_q[idx_q];

  mc_byte_lane u_lane (
    .word_i   (word_rd),
    .lane_i   (lane_q),
    .wbyte_i  (wdata_q[7:0]),
    .sext_o   (lane_sext),
    .merged_o (lane_merged)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    byte_d       = byte_q;
    idx_d        = idx_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
          we_d    = req_we;
          byte_d  = req_byte;
          idx_d   = req_addr[ADDR_W+1:2];
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          err_d        = misalign;
          if (misalign) begin
            rdata_d = '0;
          end else if (!we_q) begin
            rdata_d = byte_q ? lane_sext : word_rd;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      idx_q        <= '0;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      byte_q       <= byte_d;
      idx_q        <= idx_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Array is not reset; a reset clears state_q so a pending store never reaches its access edge.
  always_ff @(posedge clk) begin
    if (access && we_q && !misalign) begin
      mem_q[idx_q] <= byte_q ? lane_merged : wdata_q;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mc_mem_responder.sv
// tb/tb_mc_mem_responder.sv - scoreboard bench for mc_mem_responder
module tb_mc_mem_responder;

  localparam int W_A = 2;
  localparam int W_B = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic        rv_a = 1'b0, we_a = 1'b0, bt_a = 1'b0;
  logic [31:0] addr_a = '0, wd_a = '0;
  logic        rdy_a, rsv_a, err_a, busy_a;
  logic [31:0] rd_a;

  logic        rv_b = 1'b0, we_b = 1'b0, bt_b = 1'b0;
  logic [31:0] addr_b = '0, wd_b = '0;
  logic        rdy_b, rsv_b, err_b, busy_b;
  logic [31:0] rd_b;

  exp_t        q_a[$];
  exp_t        q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mc_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(W_A)) dut_a (
    .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(rdy_a), .req_we(we_a),
    .req_byte(bt_a), .req_addr(addr_a), .req_wdata(wd_a), .resp_valid(rsv_a),
    .resp_rdata(rd_a), .resp_err(err_a), .busy(busy_a)
  );

  mc_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(W_B)) dut_b (
    .clk(clk), .rst(rst), .req_valid(rv_b), .req_ready(rdy_b), .req_we(we_b),
    .req_byte(bt_b), .req_addr(addr_b), .req_wdata(wd_b), .resp_valid(rsv_b),
    .resp_rdata(rd_b), .resp_err(err_b), .busy(busy_b)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsv_a) begin
        if (q_a.size() == 0) chk("a_unexpected_resp", 32'd1, 32'd0);
        else begin
          e = q_a.pop_front();
          chk("a_rdata", rd_a, e.rdata);
          chk("a_err", {31'd0, err_a}, {31'd0, e.err});
          chk("a_resp_edge", cyc, e.at_cyc);
        end
      end
      if (rsv_b) begin
        if (q_b.size() == 0) chk("b_unexpected_resp", 32'd1, 32'd0);
        else begin
          e = q_b.pop_front();
          chk("b_rdata", rd_b, e.rdata);
          chk("b_err", {31'd0, err_b}, {31'd0, e.err});
          chk("b_resp_edge", cyc, e.at_cyc);
        end
      end
    end
  endtask

  task automatic issue(input int inst, input logic we, input logic bt, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                       input bit expect_resp, input bit hold, output int acc);
    int   n;
    exp_t e;
    if (inst == 0) begin
      rv_a = 1'b1; we_a = we; bt_a = bt; addr_a = addr; wd_a = wdata;
    end else begin
      rv_b = 1'b1; we_b = we; bt_b = bt; addr_b = addr; wd_b = wdata;
    end
    n = 0;
    while (!(inst == 0 ? rdy_a : rdy_b) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk("accept_timeout", n, 32'd0);
    acc = cyc + 1;
    if (expect_resp) begin
      e.rdata  = exp_rd;
      e.err    = exp_err;
      e.at_cyc = acc + ((inst == 0) ? W_A : W_B) + 1;
      if (inst == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
    @(negedge clk);
    if (!hold) begin
      if (inst == 0) rv_a = 1'b0;
      else rv_b = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", n, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc1, acc2;
    fork
      monitor();
    join_none

    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy_a}, 32'd1);
    chk("rst_valid", {31'd0, rsv_a}, 32'd0);
    chk("rst_rdata", rd_a, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store then load, busy/ready during WAIT
    issue(0, 1, 0, 32'h10, 32'h1234_5678, 32'h0, 0, 1, 0, acc0);
    chk("wait_busy", {31'd0, busy_a}, 32'd1);
    chk("wait_ready", {31'd0, rdy_a}, 32'd0);
    drain();
    issue(0, 0, 0, 32'h10, 32'h0, 32'h1234_5678, 0, 1, 0, acc0);
    drain();

    // Byte store and byte loads
    issue(0, 1, 1, 32'h11, 32'hFFFF_FFAB, 32'h1234_5678, 0, 1, 0, acc0);
    drain();
    issue(0, 0, 0, 32'h10, 32'h0, 32'h1234_AB78, 0, 1, 0, acc0);
    drain();
    issue(0, 0, 1, 32'h11, 32'h0, 32'hFFFF_FFAB, 0, 1, 0, acc0);
    drain();
    issue(0, 0, 1, 32'h10, 32'h0, 32'h0000_0078, 0, 1, 0, acc0);
    drain();
    issue(0, 0, 1, 32'h13, 32'h0, 32'h0000_0012, 0, 1, 0, acc0);
    drain();

    // Misaligned word load and store
    issue(0, 0, 0, 32'h12, 32'h0, 32'h0, 1, 1, 0, acc0);
    drain();
    issue(0, 1, 0, 32'h12, 32'h5555_5555, 32'h0, 1, 1, 0, acc0);
    drain();
    issue(0, 0, 0, 32'h10, 32'h0, 32'h1234_AB78, 0, 1, 0, acc0);
    drain();

    // req_valid held continuously across three requests
    issue(0, 0, 0, 32'h10, 32'h0, 32'h1234_AB78, 0, 1, 1, acc0);
    issue(0, 0, 1, 32'h12, 32'h0, 32'h0000_0034, 0, 1, 1, acc1);
    issue(0, 0, 0, 32'h10, 32'h0, 32'h1234_AB78, 0, 1, 0, acc2);
    chk("hold_gap1", acc1 - acc0, W_A + 3);
    chk("hold_gap2", acc2 - acc1, W_A + 3);
    drain();

    // Reset during a pending store
    issue(0, 1, 0, 32'h20, 32'hCAFE_F00D, 32'h1234_AB78, 0, 1, 0, acc0);
    drain();
    issue(0, 1, 0, 32'h20, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, acc0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, rdy_a}, 32'd1);
    chk("mid_rst_valid", {31'd0, rsv_a}, 32'd0);
    chk("mid_rst_rdata", rd_a, 32'd0);
    chk("mid_rst_err", {31'd0, err_a}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(0, 0, 0, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 1, 0, acc0);
    drain();

    // Zero wait states and address aliasing
    issue(1, 1, 0, 32'h10, 32'h1122_3344, 32'h0, 0, 1, 0, acc0);
    drain();
    issue(1, 0, 0, 32'h1010, 32'h0, 32'h1122_3344, 0, 1, 0, acc0);
    drain();
    issue(1, 1, 1, 32'h1013, 32'h0000_0099, 32'h1122_3344, 0, 1, 0, acc0);
    drain();
    issue(1, 0, 0, 32'h10, 32'h0, 32'h9922_3344, 0, 1, 0, acc0);
    drain();
    issue(1, 0, 1, 32'h1013, 32'h0, 32'hFFFF_FF99, 0, 1, 1, acc0);
    issue(1, 0, 1, 32'h12, 32'h0, 32'h0000_0022, 0, 1, 0, acc1);
    chk("b_hold_gap", acc1 - acc0, W_B + 3);
    drain();

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
